dest_reg_pipe: RTL and testbench

- Carries the 5-bit destination-register index chosen by the register-address select mux from decode through the EX, MEM and WB pipeline stages, together with its write-enable and load flag.
- Compares the decode-stage source indices against every in-flight destination and produces forwarding selects and a load-use stall request for the hazard unit.
- Presents the WB-stage index and write-enable directly to the register-file write port.

---
 rtl/dest_reg_pipe_pkg.sv | 36 +++
 rtl/dest_stage_reg.sv | 45 ++++
 rtl/dest_reg_pipe.sv | 125 ++++++++++++
 tb/tb_dest_reg_pipe.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/dest_reg_pipe_pkg.sv
// -----------------------------------------------------------------------------
// dest_reg_pipe_pkg
// Shared definitions for the destination-register pipeline:
//   AW        register index width (32 architectural registers)
//   ZERO_REG  hardwired-zero register index, never tracked as a destination
//   fwd_sel_t forward-select encoding (RF / EX / MEM / WB)
//   stage_t   one pipeline-stage entry {dst, wen, ld}
// -----------------------------------------------------------------------------
package dest_reg_pipe_pkg;

  localparam int            AW       = 5;
  localparam logic [AW-1:0] ZERO_REG = '0;

  typedef enum logic [1:0] {
    FWD_RF  = 2'd0,
    FWD_EX  = 2'd1,
    FWD_MEM = 2'd2,
    FWD_WB  = 2'd3
  } fwd_sel_t;

  typedef struct packed {
    logic [AW-1:0] dst;
    logic          wen;
    logic          ld;
  } stage_t;

  // An empty slot. dst is forced to 0 so stage indices stay deterministic.
  localparam stage_t BUBBLE = '{dst: '0, wen: 1'b0, ld: 1'b0};

  // A stage matches a source when it writes and its index equals the source.
  // The zero register never forwards.
  function automatic logic stage_hit(input stage_t s, input logic [AW-1:0] src);
    return s.wen && (s.dst == src) && (src != ZERO_REG);
  endfunction

endpackage

// File: rtl/dest_stage_reg.sv
// -----------------------------------------------------------------------------
// dest_stage_reg
// One pipeline-stage entry {dst, wen, ld} with load and bubble-clear controls.
// Ports:
//   clk       core clock
//   reset     synchronous, active-high; clears the entry to a bubble
//   i_load    capture i_dst/i_wen/i_ld this cycle
//   i_bubble  capture a bubble instead (wins over i_load)
//   i_dst/i_wen/i_ld  incoming entry
//   o_dst/o_wen/o_ld  registered entry
// -----------------------------------------------------------------------------
module dest_stage_reg
  import dest_reg_pipe_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          i_load,
  input  logic          i_bubble,
  input  logic [AW-1:0] i_dst,
  input  logic          i_wen,
  input  logic          i_ld,
  output logic [AW-1:0] o_dst,
  output logic          o_wen,
  output logic          o_ld
);

  stage_t r_entry;

  always_ff @(posedge clk) begin
    // NOTE: state is written with non-blocking assignments so every stage
    // samples its neighbour's pre-edge value and the pipe shifts cleanly.
    if (reset) begin
      r_entry <= BUBBLE;
    end else if (i_bubble) begin
      r_entry <= BUBBLE;
    end else if (i_load) begin
      r_entry <= '{dst: i_dst, wen: i_wen, ld: i_ld};
    end
  end

  assign o_dst = r_entry.dst;
  assign o_wen = r_entry.wen;
  assign o_ld  = r_entry.ld;

endmodule

// File: rtl/dest_reg_pipe.sv
// -----------------------------------------------------------------------------
// dest_reg_pipe
// Carries the decode-stage destination index, write-enable and load flag
// through EX, MEM and WB; produces forwarding selects for both decode sources
// and a load-use stall request.
// Ports:
//   clk, reset                 core clock, synchronous active-high reset
//   dst_in, wen_in, ld_in      decode destination, write flag, load flag
//   stall                      decode frozen: bubble into EX
//   flush                      kill decode and EX (EX and MEM get bubbles)
//   rs_idx, rt_idx             decode source indices
//   ex_/mem_/wb_dst, _wen      registered stage contents (WB feeds regfile)
//   fwd_a, fwd_b               forward selects (0 RF, 1 EX, 2 MEM, 3 WB)
//   lu_stall                   load-use hazard request
// stall/flush only steer register loads; no output depends on them
// combinationally.
// -----------------------------------------------------------------------------
module dest_reg_pipe
  import dest_reg_pipe_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] dst_in,
  input  logic          wen_in,
  input  logic          ld_in,
  input  logic          stall,
  input  logic          flush,
  input  logic [AW-1:0] rs_idx,
  input  logic [AW-1:0] rt_idx,
  output logic [AW-1:0] ex_dst,
  output logic [AW-1:0] mem_dst,
  output logic [AW-1:0] wb_dst,
  output logic          ex_wen,
  output logic          mem_wen,
  output logic          wb_wen,
  output logic [1:0]    fwd_a,
  output logic [1:0]    fwd_b,
  output logic          lu_stall
);

  stage_t   w_dec;
  stage_t   w_ex;
  stage_t   w_mem;
  stage_t   w_wb;
  fwd_sel_t w_fwd_a;
  fwd_sel_t w_fwd_b;
  logic     w_r0_write;

  // A write aimed at r0 is dropped at the door and travels as a bubble.
  assign w_r0_write = wen_in && (dst_in == ZERO_REG);
  assign w_dec      = w_r0_write ? BUBBLE
                                 : '{dst: dst_in, wen: wen_in, ld: ld_in};

  // EX: bubble on stall or flush (flush overrides stall, same result).
  dest_stage_reg u_ex (
    .clk      (clk),
    .reset    (reset),
    .i_load   (1'b1),
    .i_bubble (stall || flush),
    .i_dst    (w_dec.dst),
    .i_wen    (w_dec.wen),
    .i_ld     (w_dec.ld),
    .o_dst    (w_ex.dst),
    .o_wen    (w_ex.wen),
    .o_ld     (w_ex.ld)
  );

  // MEM: the EX instruction is killed by a flush.
  dest_stage_reg u_mem (
    .clk      (clk),
    .reset    (reset),
    .i_load   (1'b1),
    .i_bubble (flush),
    .i_dst    (w_ex.dst),
    .i_wen    (w_ex.wen),
    .i_ld     (w_ex.ld),
    .o_dst    (w_mem.dst),
    .o_wen    (w_mem.wen),
    .o_ld     (w_mem.ld)
  );

  // WB: whatever reached MEM always completes.
  dest_stage_reg u_wb (
    .clk      (clk),
    .reset    (reset),
    .i_load   (1'b1),
    .i_bubble (1'b0),
    .i_dst    (w_mem.dst),
    .i_wen    (w_mem.wen),
    .i_ld     (w_mem.ld),
    .o_dst    (w_wb.dst),
    .o_wen    (w_wb.wen),
    .o_ld     (w_wb.ld)
  );

  // Forward compare, one copy per source; the youngest matching stage wins.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path
    // through the block leaves it unassigned (which would infer a latch).
    w_fwd_a = FWD_RF;
    if      (stage_hit(w_ex,  rs_idx)) w_fwd_a = FWD_EX;
    else if (stage_hit(w_mem, rs_idx)) w_fwd_a = FWD_MEM;
    else if (stage_hit(w_wb,  rs_idx)) w_fwd_a = FWD_WB;
  end

  always_comb begin
    w_fwd_b = FWD_RF;
    if      (stage_hit(w_ex,  rt_idx)) w_fwd_b = FWD_EX;
    else if (stage_hit(w_mem, rt_idx)) w_fwd_b = FWD_MEM;
    else if (stage_hit(w_wb,  rt_idx)) w_fwd_b = FWD_WB;
  end

  // A load in EX cannot forward its data yet: any consumer must wait a cycle.
  assign lu_stall = w_ex.ld && (stage_hit(w_ex, rs_idx) || stage_hit(w_ex, rt_idx));

  assign fwd_a   = w_fwd_a;
  assign fwd_b   = w_fwd_b;
  assign ex_dst  = w_ex.dst;
  assign ex_wen  = w_ex.wen;
  assign mem_dst = w_mem.dst;
  assign mem_wen = w_mem.wen;
  assign wb_dst  = w_wb.dst;
  assign wb_wen  = w_wb.wen;

endmodule

// File: tb/tb_dest_reg_pipe.sv
// -----------------------------------------------------------------------------
// tb_dest_reg_pipe
// Directed stimulus pushes the hand-computed expected output snapshot for the
// current cycle into a scoreboard queue; a negedge monitor pops and compares.
// -----------------------------------------------------------------------------
module tb_dest_reg_pipe;
  import dest_reg_pipe_pkg::*;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] dst_in;
  logic          wen_in;
  logic          ld_in;
  logic          stall;
  logic          flush;
  logic [AW-1:0] rs_idx;
  logic [AW-1:0] rt_idx;
  logic [AW-1:0] ex_dst, mem_dst, wb_dst;
  logic          ex_wen, mem_wen, wb_wen;
  logic [1:0]    fwd_a, fwd_b;
  logic          lu_stall;

  dest_reg_pipe dut (
    .clk      (clk),
    .reset    (reset),
    .dst_in   (dst_in),
    .wen_in   (wen_in),
    .ld_in    (ld_in),
    .stall    (stall),
    .flush    (flush),
    .rs_idx   (rs_idx),
    .rt_idx   (rt_idx),
    .ex_dst   (ex_dst),
    .mem_dst  (mem_dst),
    .wb_dst   (wb_dst),
    .ex_wen   (ex_wen),
    .mem_wen  (mem_wen),
    .wb_wen   (wb_wen),
    .fwd_a    (fwd_a),
    .fwd_b    (fwd_b),
    .lu_stall (lu_stall)
  );

  always #5 clk = ~clk;

  // Snapshot layout: ex_dst ex_wen mem_dst mem_wen wb_dst wb_wen fa fb lu
  typedef struct {
    int          cyc;
    string       name;
    logic [22:0] v;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic string fmt(input logic [22:0] v);
    return $sformatf("ex=%0d/%0b mem=%0d/%0b wb=%0d/%0b fa=%0d fb=%0d lu=%0b",
                     v[22:18], v[17], v[16:12], v[11], v[10:6], v[5],
                     v[4:3], v[2:1], v[0]);
  endfunction

  task automatic check(input string name, input logic [22:0] act, input logic [22:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s cyc=%0d got {%s} expected {%s}", name, cyc, fmt(act), fmt(req));
    end
  endtask

  // Monitor: compares the snapshot scheduled for this cycle; stale entries
  // (never compared in their cycle) count as failures.
  always @(negedge clk) begin
    exp_t e;
    while (sb_q.size() > 0 && sb_q[0].cyc < cyc) begin
      e = sb_q.pop_front();
      checks++;
      errors++;
      $display("FAIL %s missed at cyc=%0d", e.name, e.cyc);
    end
    if (sb_q.size() > 0 && sb_q[0].cyc == cyc) begin
      e = sb_q.pop_front();
      check(e.name, {ex_dst, ex_wen, mem_dst, mem_wen, wb_dst, wb_wen,
                     fwd_a, fwd_b, lu_stall}, e.v);
    end
  end

  task automatic drive(input int d, input int w, input int l, input int rs,
                       input int rt, input int st, input int fl);
    dst_in = AW'(d);
    wen_in = 1'(w);
    ld_in  = 1'(l);
    rs_idx = AW'(rs);
    rt_idx = AW'(rt);
    stall  = 1'(st);
    flush  = 1'(fl);
  endtask

  task automatic expect_now(input string name, input int exd, input int exw,
                            input int md, input int mw, input int wd, input int ww,
                            input int fa, input int fb, input int lu);
    exp_t e;
    e.cyc  = cyc;
    e.name = name;
    e.v    = {AW'(exd), 1'(exw), AW'(md), 1'(mw), AW'(wd), 1'(ww),
              2'(fa), 2'(fb), 1'(lu)};
    sb_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset held for two cycles while a write to r7 is presented.
    reset = 1'b1;
    drive(7, 1, 0, 0, 0, 0, 0);
    tick();
    expect_now("reset_hold",    0,0, 0,0, 0,0, 0,0,0); tick();
    reset = 1'b0;
    expect_now("reset_release", 0,0, 0,0, 0,0, 0,0,0); tick();
    // r7 travels EX -> MEM -> WB, reaching WB three cycles after entry.
    drive(0, 0, 0, 0, 0, 0, 0);
    expect_now("lat_ex",        7,1, 0,0, 0,0, 0,0,0); tick();
    expect_now("lat_mem",       0,0, 7,1, 0,0, 0,0,0); tick();
    expect_now("lat_wb",        0,0, 0,0, 7,1, 0,0,0); tick();

    // Forwarding priority: writes r5, r5, r9; then read rs=5, rt=9.
    drive(5, 1, 0, 0, 0, 0, 0);
    expect_now("fwd_idle",      0,0, 0,0, 0,0, 0,0,0); tick();
    drive(5, 1, 0, 0, 0, 0, 0);
    expect_now("fill_5a",       5,1, 0,0, 0,0, 0,0,0); tick();
    drive(9, 1, 0, 0, 0, 0, 0);
    expect_now("fill_5b",       5,1, 5,1, 0,0, 0,0,0); tick();
    drive(0, 0, 0, 5, 9, 0, 0);
    expect_now("fwd_mem_over_wb", 9,1, 5,1, 5,1, 2,1,0); tick();
    expect_now("fwd_wb_mem",    0,0, 9,1, 5,1, 3,2,0); tick();
    // r0 write presented while rs=5 (gone) and rt=9 (in WB).
    drive(0, 1, 0, 5, 9, 0, 0);
    expect_now("fwd_wb_only",   0,0, 0,0, 9,1, 0,3,0); tick();

    // r0 filter: the r0 write never shows a write flag anywhere.
    drive(0, 0, 0, 0, 0, 0, 0);
    expect_now("r0_filter_ex",  0,0, 0,0, 0,0, 0,0,0); tick();
    expect_now("r0_filter_mem", 0,0, 0,0, 0,0, 0,0,0); tick();
    drive(12, 1, 1, 0, 0, 0, 0);
    expect_now("r0_filter_wb",  0,0, 0,0, 0,0, 0,0,0); tick();

    // Load-use on source B: load r12, consumer reads rt=12, stall returned.
    drive(0, 0, 0, 0, 12, 1, 0);
    expect_now("lu_hit_rt",    12,1, 0,0, 0,0, 0,1,1); tick();
    drive(0, 0, 0, 0, 12, 0, 0);
    expect_now("lu_after_stall", 0,0, 12,1, 0,0, 0,2,0); tick();
    drive(20, 1, 1, 0, 0, 0, 0);
    expect_now("lu_wb",         0,0, 0,0, 12,1, 0,0,0); tick();
    // Load-use on source A with load r20.
    drive(0, 0, 0, 20, 0, 1, 0);
    expect_now("lu_hit_rs",    20,1, 0,0, 0,0, 1,0,1); tick();
    drive(0, 0, 0, 20, 0, 0, 0);
    expect_now("lu_rs_clear",   0,0, 20,1, 0,0, 2,0,0); tick();

    // Flush: fill EX=r3, MEM=r4, WB=r6, then flush with stall also high.
    drive(6, 1, 0, 0, 0, 0, 0);
    expect_now("lu_rs_wb",      0,0, 0,0, 20,1, 0,0,0); tick();
    drive(4, 1, 0, 0, 0, 0, 0);
    expect_now("fill_6",        6,1, 0,0, 0,0, 0,0,0); tick();
    drive(3, 1, 0, 0, 0, 0, 0);
    expect_now("fill_4",        4,1, 6,1, 0,0, 0,0,0); tick();
    drive(8, 1, 0, 0, 0, 1, 1);
    expect_now("pre_flush",     3,1, 4,1, 6,1, 0,0,0); tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    expect_now("post_flush",    0,0, 0,0, 4,1, 0,0,0); tick();

    // Mid-operation reset with r1, r2, r3 in flight; reset beats a new write.
    drive(1, 1, 0, 0, 0, 0, 0);
    expect_now("flush_drain",   0,0, 0,0, 0,0, 0,0,0); tick();
    drive(2, 1, 0, 0, 0, 0, 0);
    expect_now("fill_1",        1,1, 0,0, 0,0, 0,0,0); tick();
    drive(3, 1, 0, 0, 0, 0, 0);
    expect_now("fill_2",        2,1, 1,1, 0,0, 0,0,0); tick();
    reset = 1'b1;
    drive(9, 1, 0, 0, 0, 0, 0);
    expect_now("pre_reset",     3,1, 2,1, 1,1, 0,0,0); tick();
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    expect_now("post_reset_0",  0,0, 0,0, 0,0, 0,0,0); tick();
    expect_now("post_reset_1",  0,0, 0,0, 0,0, 0,0,0); tick();
    expect_now("post_reset_2",  0,0, 0,0, 0,0, 0,0,0); tick();

    // Let the monitor drain, then flag anything it never reached.
    tick();
    tick();
    while (sb_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL %s never compared (cyc=%0d)", sb_q[0].name, sb_q[0].cyc);
      void'(sb_q.pop_front());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
